qdivs: RTL and testbench

- Sequential sign-magnitude fixed-point divider: o_quotient_out = i_dividend / i_divisor.
- Restoring long division, one quotient bit per clock.
- Inverse companion to the shift-and-add fixed-point multiplier. Uses the same Q/N number format and the same i_start / o_complete handshake, so DSP datapaths can drop it in.

---
 rtl/qdivs_pkg.sv | 8 +
 rtl/qdivs.sv | 73 +++++++
 tb/tb_qdivs.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/qdivs_pkg.sv
// qdivs_pkg: default Q-format parameters and iteration-count helper for the fixed-point divider
package qdivs_pkg;
  localparam int DEF_Q = 15;
  localparam int DEF_N = 32;
  function automatic int iter_count(int n, int q);
    return n - 1 + q;
  endfunction
endpackage

// File: rtl/qdivs.sv
// qdivs: sequential sign-magnitude Q-format restoring divider, one quotient bit per clock
module qdivs
  import qdivs_pkg::*;
#(
  parameter int Q = DEF_Q,
  parameter int N = DEF_N
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  input  logic         i_start,
  output logic [N-1:0] o_quotient_out,
  output logic         o_complete,
  output logic         o_overflow
);
  localparam int MW = N - 1;
  localparam int SW = iter_count(N, Q);
  localparam int CW = $clog2(N + Q);
  localparam logic [MW-1:0] SAT = '1;
  logic [SW-1:0] dvd_q, quo_q, quo_d;
  logic [MW-1:0] b_q, mag_d;
  logic [N-1:0]  rem_q, rem_d, out_q, out_d;
  logic [N:0]    rem_sh;
  logic [CW-1:0] cnt_q;
  logic          sign_q, done_q, ovf_q, ge, ovf_d, last;
  always_comb begin
    rem_sh = {rem_q, dvd_q[SW-1]};
    ge     = rem_sh >= {2'b0, b_q};
    rem_d  = N'(ge ? rem_sh - {2'b0, b_q} : rem_sh);
    quo_d  = SW'({quo_q, ge});
    ovf_d  = (b_q == '0) || (|quo_d[SW-1:MW]);
    mag_d  = ovf_d ? SAT : quo_d[MW-1:0];
    out_d  = {sign_q & (|mag_d), mag_d};
    last   = cnt_q == CW'(SW - 1);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      done_q <= 1'b1;
      out_q  <= '0;
      ovf_q  <= 1'b0;
      dvd_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      sign_q <= 1'b0;
    end else if (done_q) begin
      if (i_start) begin
        dvd_q  <= {i_dividend[N-2:0], {Q{1'b0}}};
        b_q    <= i_divisor[N-2:0];
        sign_q <= i_dividend[N-1] ^ i_divisor[N-1];
        rem_q  <= '0;
        quo_q  <= '0;
        cnt_q  <= '0;
        done_q <= 1'b0;
      end
    end else begin
      dvd_q <= dvd_q << 1;
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + 1'b1;
      if (last) begin
        done_q <= 1'b1;
        out_q  <= out_d;
        ovf_q  <= ovf_d;
      end
    end
  end
  assign o_quotient_out = out_q;
  assign o_complete     = done_q;
  assign o_overflow     = ovf_q;
endmodule

// File: tb/tb_qdivs.sv
// tb_qdivs: directed + model-checked scoreboard bench for the qdivs divider
module tb_qdivs;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_dividend = '0;
  logic [31:0] i_divisor = '0;
  logic        i_start = 1'b0;
  logic [31:0] o_quotient_out;
  logic        o_complete;
  logic        o_overflow;
  int          total = 0;
  int          passed = 0;
  logic [32:0] sb[$];

  qdivs dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_dividend(i_dividend), .i_divisor(i_divisor),
    .i_start(i_start), .o_quotient_out(o_quotient_out), .o_complete(o_complete),
    .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] m;
    logic [30:0] mag;
    logic        ov;
    if (b[30:0] == 0) begin
      ov = 1'b1;
      mag = '1;
    end else begin
      m = ({33'd0, a[30:0]} << 15) / {33'd0, b[30:0]};
      ov = (m >> 31) != 0;
      mag = ov ? '1 : m[30:0];
    end
    return {ov, (a[31] ^ b[31]) & (mag != 0), mag};
  endfunction

  task automatic wait_done(output int n, input bit pulse);
    n = 0;
    while (!o_complete && n < 200) begin
      n++;
      i_start = pulse && (n == 5 || n == 20);
      @(negedge i_clk);
    end
    i_start = 1'b0;
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [32:0] e);
    @(negedge i_clk);
    i_dividend = a;
    i_divisor = b;
    i_start = 1'b1;
    sb.push_back(e);
    @(negedge i_clk);
    i_start = 1'b0;
    i_dividend = $urandom;
    i_divisor = $urandom;
  endtask

  task automatic finish_op(input string tag, input bit pulse);
    int n;
    logic [32:0] e;
    wait_done(n, pulse);
    chk({tag, "_lat"}, n, 46);
    e = sb.size() != 0 ? sb.pop_front() : 33'h1_DEAD_BEEF;
    chk({tag, "_q"}, o_quotient_out, e[31:0]);
    chk({tag, "_ovf"}, {31'd0, o_overflow}, {31'd0, e[32]});
  endtask

  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] eq, input logic eo);
    launch(a, b, {eo, eq});
    finish_op(tag, 1'b0);
  endtask

  initial begin
    int n;
    logic [31:0] a, b;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    chk("rst_done", {31'd0, o_complete}, 32'd1);
    chk("rst_q", o_quotient_out, 32'd0);
    chk("rst_ovf", {31'd0, o_overflow}, 32'd0);
    op("d3_2", 32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0);
    op("dm1_4", 32'h8000_8000, 32'h0002_0000, 32'h8000_2000, 1'b0);
    op("dm1_m4", 32'h8000_8000, 32'h8002_0000, 32'h0000_2000, 1'b0);
    op("d1_3", 32'h0000_8000, 32'h0001_8000, 32'h0000_2AAA, 1'b0);
    op("d0_m1", 32'h0000_0000, 32'h8000_8000, 32'h0000_0000, 1'b0);
    op("ovf", 32'h7FFF_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
    op("dz", 32'h8000_8000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
    op("clr_ovf", 32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0);
    launch(32'h0000_8000, 32'h0001_8000, {1'b0, 32'h0000_2AAA});
    finish_op("ign_start", 1'b1);
    for (int k = 0; k < 6; k++) begin
      a = $urandom;
      b = $urandom & ((k % 2) ? 32'h8000_0FFF : 32'h803F_FFFF);
      launch(a, b, model(a, b));
      finish_op("rand", 1'b0);
    end
    // start held high across a completion: exactly one idle cycle between ops
    @(negedge i_clk);
    i_dividend = 32'h0001_8000;
    i_divisor = 32'h0001_0000;
    i_start = 1'b1;
    sb.push_back({1'b0, 32'h0000_C000});
    @(negedge i_clk);
    i_dividend = 32'h8000_8000;
    i_divisor = 32'h0002_0000;
    n = 0;
    while (!o_complete && n < 200) begin
      n++;
      @(negedge i_clk);
    end
    chk("b2b1_lat", n, 46);
    chk("b2b1_q", o_quotient_out, sb.size() != 0 ? sb.pop_front() : 32'hDEAD_BEEF);
    sb.push_back({1'b0, 32'h8000_2000});
    @(negedge i_clk);
    i_start = 1'b0;
    chk("b2b_gap", {31'd0, o_complete}, 32'd0);
    finish_op("b2b2", 1'b0);
    op("dz2", 32'h8000_8000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
    @(negedge i_clk);
    i_dividend = 32'h0001_8000;
    i_divisor = 32'h0001_0000;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (10) @(negedge i_clk);
    chk("hold_q", o_quotient_out, 32'hFFFF_FFFF);
    chk("hold_ovf", {31'd0, o_overflow}, 32'd1);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("mid_rst_done", {31'd0, o_complete}, 32'd1);
    chk("mid_rst_q", o_quotient_out, 32'd0);
    chk("mid_rst_ovf", {31'd0, o_overflow}, 32'd0);
    op("post_rst", 32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0);
    @(negedge i_clk);
    i_rst = 1'b1;
    i_start = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    i_start = 1'b0;
    @(negedge i_clk);
    chk("rst_start_done", {31'd0, o_complete}, 32'd1);
    chk("rst_start_q", o_quotient_out, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
